icache_direct: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the IF stage and the instruction-fetch port of the memory controller. On a hit it returns the 32-bit instruction one cycle after the request is accepted, without touching the byte-serial RAM path. On a miss it issues a single word fetch to the memory controller, fills the line and returns the word. It honours the IF discard (branch redirect) signal in both lookup and miss states.

---
 rtl/icache_direct.sv | 134 +++++++++++++
 tb/tb_icache_direct.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache that sits
// between the IF stage and the instruction-fetch port of the memory controller.
// Hits return one cycle after acceptance; misses fetch a single word, fill the
// line and return it. A discard from IF abandons the current request.
module icache_direct #(
   parameter  int INDEX_BITS = 6,
   localparam int TAG_BITS   = 32 - INDEX_BITS - 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic        discard_i,
   input  logic        flush_i,
   output logic        ready_o,
   output logic [31:0] data_o,
   output logic        busy_o,
   output logic        mem_if_read_o,
   output logic [31:0] mem_if_addr_o,
   output logic        mem_if_discard_o,
   input  logic        mem_if_ready_i,
   input  logic [31:0] mem_if_data_i
);

   localparam int LINES = 1 << INDEX_BITS;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic [31:0]         data_q, data_d;
   logic [31:0]         miss_addr_q, miss_addr_d;
   logic [LINES-1:0]    valid_q, valid_d;

   // Tag and data storage are never reset; only the valid bits qualify them.
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_BITS-1:0]   req_tag, fill_tag;
   logic                  hit;
   logic                  accept;
   logic                  fill_en;

   assign req_idx  = addr_i[INDEX_BITS+1:2];
   assign req_tag  = addr_i[31:INDEX_BITS+2];
   assign fill_idx = miss_addr_q[INDEX_BITS+1:2];
   assign fill_tag = miss_addr_q[31:INDEX_BITS+2];

   // Lookup is combinational on the live address so a hit can be answered
   // at the very edge that accepts the request.
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   // Never accept while ready is high: IF may change addr in the ready cycle.
   assign accept  = req_i && !ready_q && !discard_i;
   // A fill is written even if discard arrives with the data; the word is
   // still correct for miss_addr.
   assign fill_en = (state_q == MISS) && mem_if_ready_i;

   // Next-state, response and miss-address logic for the two-state FSM.
   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      data_d      = data_q;
      miss_addr_d = miss_addr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (hit) begin
                  ready_d = 1'b1;
                  data_d  = data_mem[req_idx];
               end else begin
                  miss_addr_d = addr_i;
                  state_d     = MISS;
               end
            end
         end
         MISS: begin
            if (mem_if_ready_i) begin
               state_d = IDLE;
               data_d  = mem_if_data_i;
               ready_d = !discard_i;
            end else if (discard_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Valid bits: flush clears everything first, then a completing fill sets
   // its own line so it survives a flush in the same cycle.
   always_comb begin
      valid_d = flush_i ? '0 : valid_q;
      if (fill_en) begin
         valid_d[fill_idx] = 1'b1;
      end
   end

   // Control state and valid bits, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         data_q      <= '0;
         miss_addr_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         data_q      <= data_d;
         miss_addr_q <= miss_addr_d;
         valid_q     <= valid_d;
      end
   end

   // Line fill of tag and data arrays; no reset so they map to plain RAM.
   always_ff @(posedge clk_i) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_if_data_i;
      end
   end

   assign ready_o          = ready_q;
   assign data_o           = data_q;
   assign busy_o           = (state_q == MISS);
   assign mem_if_read_o    = (state_q == MISS);
   assign mem_if_addr_o    = (state_q == MISS) ? miss_addr_q : 32'h0;
   assign mem_if_discard_o = discard_i;

endmodule

// File: tb/tb_icache_direct.sv
// Directed testbench for icache_direct: one task per scenario, each checking
// the outputs against hand-computed values.
module tb_icache_direct;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        discard;
   logic        flush;
   logic        ready;
   logic [31:0] data;
   logic        busy;
   logic        mem_if_read;
   logic [31:0] mem_if_addr;
   logic        mem_if_discard;
   logic        mem_if_ready;
   logic [31:0] mem_if_data;

   int n_cmp = 0;
   int n_err = 0;

   icache_direct #(.INDEX_BITS(6)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .req_i            (req),
      .addr_i           (addr),
      .discard_i        (discard),
      .flush_i          (flush),
      .ready_o          (ready),
      .data_o           (data),
      .busy_o           (busy),
      .mem_if_read_o    (mem_if_read),
      .mem_if_addr_o    (mem_if_addr),
      .mem_if_discard_o (mem_if_discard),
      .mem_if_ready_i   (mem_if_ready),
      .mem_if_data_i    (mem_if_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: serve a miss on a line known to be absent.
   task automatic fill_line(input logic [31:0] a, input logic [31:0] w);
      req = 1'b1; addr = a;
      cyc();
      mem_if_ready = 1'b1; mem_if_data = w;
      cyc();
      mem_if_ready = 1'b0; req = 1'b0;
      cyc();
   endtask

   // Stimulus only: abandon the current miss.
   task automatic cancel();
      req = 1'b0; discard = 1'b1;
      cyc();
      discard = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 1'b0; addr = '0; discard = 1'b0; flush = 1'b0;
      mem_if_ready = 1'b0; mem_if_data = '0;
      #3;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (mem_if_read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", mem_if_read); end
      n_cmp++; if (mem_if_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", mem_if_addr); end
      discard = 1'b1; #1;
      n_cmp++; if (mem_if_discard !== 1'b1) begin n_err++; $display("FAIL reset_discard_pass: got %b want 1", mem_if_discard); end
      discard = 1'b0; #1;
      n_cmp++; if (mem_if_discard !== 1'b0) begin n_err++; $display("FAIL reset_discard_low: got %b want 0", mem_if_discard); end
      cyc();
      rst_n = 1'b1;
      cyc();
      $display("test_reset done");
   endtask

   task automatic test_miss_fill();
      req = 1'b1; addr = 32'h0000_0100;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL miss_busy: got %b want 1", busy); end
      n_cmp++; if (mem_if_read !== 1'b1) begin n_err++; $display("FAIL miss_read1: got %b want 1", mem_if_read); end
      n_cmp++; if (mem_if_addr !== 32'h0000_0100) begin n_err++; $display("FAIL miss_addr: got %h want 00000100", mem_if_addr); end
      cyc();
      n_cmp++; if (mem_if_read !== 1'b1) begin n_err++; $display("FAIL miss_read_held: got %b want 1", mem_if_read); end
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL miss_ready_early: got %b want 0", ready); end
      mem_if_ready = 1'b1; mem_if_data = 32'h0050_0093;
      cyc();
      mem_if_ready = 1'b0; req = 1'b0;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL miss_ready: got %b want 1", ready); end
      n_cmp++; if (data !== 32'h0050_0093) begin n_err++; $display("FAIL miss_data: got %h want 00500093", data); end
      n_cmp++; if (mem_if_read !== 1'b0) begin n_err++; $display("FAIL miss_read_drop: got %b want 0", mem_if_read); end
      cyc();
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL miss_ready_pulse: got %b want 0", ready); end
      $display("test_miss_fill done");
   endtask

   task automatic test_hit();
      req = 1'b1; addr = 32'h0000_0100;
      cyc();
      req = 1'b0;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL hit_ready: got %b want 1", ready); end
      n_cmp++; if (data !== 32'h0050_0093) begin n_err++; $display("FAIL hit_data: got %h want 00500093", data); end
      n_cmp++; if (mem_if_read !== 1'b0) begin n_err++; $display("FAIL hit_no_read: got %b want 0", mem_if_read); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hit_busy: got %b want 0", busy); end
      cyc();
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL hit_ready_pulse: got %b want 0", ready); end
      $display("test_hit done");
   endtask

   task automatic test_back_to_back();
      logic [2:0] seen;
      req = 1'b1; addr = 32'h0000_0100;
      for (int i = 0; i < 3; i++) begin
         cyc();
         seen[i] = ready;
      end
      req = 1'b0;
      n_cmp++; if (seen !== 3'b101) begin n_err++; $display("FAIL b2b_pattern: got %b want 101 (lsb first cycle)", seen); end
      cyc();
      $display("test_back_to_back done");
   endtask

   task automatic test_conflict();
      req = 1'b1; addr = 32'h0000_0200;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL conflict_miss: got %b want 1", busy); end
      n_cmp++; if (mem_if_addr !== 32'h0000_0200) begin n_err++; $display("FAIL conflict_addr: got %h want 00000200", mem_if_addr); end
      mem_if_ready = 1'b1; mem_if_data = 32'h1234_5678;
      cyc();
      mem_if_ready = 1'b0; req = 1'b0;
      n_cmp++; if (data !== 32'h1234_5678) begin n_err++; $display("FAIL conflict_data: got %h want 12345678", data); end
      cyc();
      req = 1'b1; addr = 32'h0000_0200;
      cyc();
      req = 1'b0;
      n_cmp++; if (ready !== 1'b1 || data !== 32'h1234_5678) begin n_err++; $display("FAIL conflict_rehit: got ready=%b data=%h want 1 12345678", ready, data); end
      cyc();
      req = 1'b1; addr = 32'h0000_0100;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL conflict_evicted: got busy=%b want 1", busy); end
      mem_if_ready = 1'b1; mem_if_data = 32'h0050_0093;
      cyc();
      mem_if_ready = 1'b0; req = 1'b0;
      cyc();
      $display("test_conflict done");
   endtask

   task automatic test_discard();
      req = 1'b1; addr = 32'h0000_0104;
      cyc();
      cyc();
      n_cmp++; if (mem_if_read !== 1'b1) begin n_err++; $display("FAIL disc_read_before: got %b want 1", mem_if_read); end
      req = 1'b0; discard = 1'b1; #1;
      n_cmp++; if (mem_if_discard !== 1'b1) begin n_err++; $display("FAIL disc_pass: got %b want 1", mem_if_discard); end
      cyc();
      discard = 1'b0;
      n_cmp++; if (mem_if_read !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL disc_idle: got read=%b busy=%b want 0 0", mem_if_read, busy); end
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL disc_ready: got %b want 0", ready); end
      cyc();
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL disc_ready_late: got %b want 0", ready); end
      req = 1'b1; addr = 32'h0000_0104;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL disc_no_fill: got busy=%b want 1", busy); end
      mem_if_ready = 1'b1; mem_if_data = 32'h00A0_0113;
      cyc();
      mem_if_ready = 1'b0; req = 1'b0;
      cyc();
      // discard arriving together with the memory data: fill kept, no ready
      req = 1'b1; addr = 32'h0000_0108;
      cyc();
      req = 1'b0; discard = 1'b1; mem_if_ready = 1'b1; mem_if_data = 32'hCAFE_F00D;
      cyc();
      discard = 1'b0; mem_if_ready = 1'b0;
      n_cmp++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL disc_with_data: got ready=%b busy=%b want 0 0", ready, busy); end
      cyc();
      req = 1'b1; addr = 32'h0000_0108;
      cyc();
      req = 1'b0;
      n_cmp++; if (ready !== 1'b1 || data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL disc_fill_kept: got ready=%b data=%h want 1 cafef00d", ready, data); end
      cyc();
      $display("test_discard done");
   endtask

   task automatic test_flush();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      req = 1'b1; addr = 32'h0000_0100;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_miss_100: got busy=%b want 1", busy); end
      cancel();
      req = 1'b1; addr = 32'h0000_0104;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_miss_104: got busy=%b want 1", busy); end
      cancel();
      fill_line(32'h0000_0100, 32'h0050_0093);
      // flush together with an accepted hit
      req = 1'b1; addr = 32'h0000_0100; flush = 1'b1;
      cyc();
      req = 1'b0; flush = 1'b0;
      n_cmp++; if (ready !== 1'b1 || data !== 32'h0050_0093) begin n_err++; $display("FAIL flush_hit: got ready=%b data=%h want 1 00500093", ready, data); end
      cyc();
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL flush_hit_once: got %b want 0", ready); end
      req = 1'b1; addr = 32'h0000_0100;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_after_hit: got busy=%b want 1", busy); end
      // fill completing together with flush stays valid
      mem_if_ready = 1'b1; mem_if_data = 32'h0050_0093; flush = 1'b1;
      cyc();
      mem_if_ready = 1'b0; flush = 1'b0; req = 1'b0;
      cyc();
      req = 1'b1; addr = 32'h0000_0100;
      cyc();
      req = 1'b0;
      n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL flush_fill_survives: got ready=%b busy=%b want 1 0", ready, busy); end
      cyc();
      $display("test_flush done");
   endtask

   task automatic test_async_reset();
      req = 1'b1; addr = 32'h0000_010C;
      cyc();
      req = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || mem_if_read !== 1'b0) begin n_err++; $display("FAIL areset_state: got busy=%b read=%b want 0 0", busy, mem_if_read); end
      n_cmp++; if (mem_if_addr !== 32'h0) begin n_err++; $display("FAIL areset_addr: got %h want 00000000", mem_if_addr); end
      n_cmp++; if (ready !== 1'b0 || data !== 32'h0) begin n_err++; $display("FAIL areset_out: got ready=%b data=%h want 0 00000000", ready, data); end
      cyc();
      #2 rst_n = 1'b1;
      cyc();
      req = 1'b1; addr = 32'h0000_0100;
      cyc();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL areset_invalidated: got busy=%b want 1", busy); end
      cancel();
      cyc();
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_miss_fill();
      test_hit();
      test_back_to_back();
      test_conflict();
      test_discard();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
